mux_scan: RTL and testbench
===========================

Name: mux_scan

Overview:
- Parametrised N-channel, W-bit registered multiplexer with an active-low strobe and complementary outputs y/w.
- Two modes:
  - Manual: the caller selects the channel.
  - Auto-scan: an internal sequencer steps through the channels with a programmable dwell time.
- Samples leave through a valid/ready output port, so downstream logic (display, UART framer) can stall the block.

Parameters:
- N_CH, 8, number of input channels (2..64; need not be a power of two).
- W, 1, data width per channel in bits.
- DWELL, 4, cycles spent on a channel in scan mode before it is sampled (0..255).
- SW (localparam), max(1,$clog2(N_CH)), select/channel-index width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- g_n  in  1  strobe, active-low; 1 disables capture.
- mode  in  1  0 = manual select, 1 = auto-scan.
- sel  in  SW  manual channel select.
- d  in  N_CH*W  packed channel data; channel k occupies d[k*W +: W].
- out_ready  in  1  downstream accepts the current sample.
- out_valid  out  1  y/w/out_ch hold a valid sample.
- y  out  W  selected channel data (registered).
- w  out  W  bitwise complement of y, always ~y.
- out_ch  out  SW  channel index of the current sample.
- scan_wrap  out  1  one-cycle pulse when the scan captures channel N_CH-1.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - y=0, w=all-ones, out_valid=0, out_ch=0, scan_wrap=0.
  - Scan pointer=0, dwell counter=0, FSM=IDLE.
- Slot free when (!out_valid || out_ready). A capture happens only when the slot is free and the capture condition holds.
- On capture, in the same edge:
  - y <= selected data; w <= ~selected data.
  - out_ch <= index; out_valid <= 1.
- Slot free with no capture: out_valid <= 0; y/w/out_ch keep their last values.
- out_valid=1 with out_ready=0: y, w and out_ch stay stable, with no change allowed.
- g_n=1:
  - No captures occur and the FSM is forced to IDLE.
  - A pending sample remains until accepted.
  - Once the slot is free, y <= 0 and w <= all-ones, matching the 74151 disabled state.
- Manual mode (mode=0):
  - Capture condition is g_n=0; latency is 1 cycle from sel/d to y.
  - sel >= N_CH captures all-zero data with out_ch=sel.
- Scan mode FSM, states IDLE, DWELL, EMIT:
  - IDLE -> DWELL when mode=1 and g_n=0; pointer=0, counter=0.
  - DWELL: the counter increments each cycle. When counter==DWELL-1, or immediately if DWELL=0, -> EMIT.
  - EMIT: capture condition true. On capture, take d[ptr], out_ch=ptr, and move to DWELL.
    - The pointer increments, wrapping from N_CH-1 to 0; the counter clears.
    - If the slot is not free, stay in EMIT; the data captured is d[ptr] on the capture edge.
  - scan_wrap=1 for exactly the cycle after a capture of channel N_CH-1; otherwise 0.
- A change of mode between cycles restarts the scan: FSM -> IDLE, pointer=0, counter=0. A pending sample is untouched.
- Minimum scan period per channel is DWELL+1 cycles when out_ready is held high.

Optional Feature:
- Macro: MUX_SCAN_CHAN_MASK_EN.
- Defined:
  - Adds input port chan_mask [N_CH-1:0], where 1 = channel enabled.
  - Scan mode skips masked-off channels. The pointer advances to the next enabled channel (cyclic) with no dwell spent on skipped ones.
  - scan_wrap pulses on capture of the highest enabled index.
  - All-zero mask holds the FSM in IDLE.
  - Manual mode on a masked channel captures zero data.
- Undefined: no chan_mask port; all channels are enabled.

Test Plan:
- Manual, N_CH=8, W=1, d=8'b1010_0110, out_ready=1, sel=1 then 7 -> y=1,w=0,out_ch=1 one cycle later; then y=1,out_ch=7.
- Manual, g_n=1 with out_ready=1 -> out_valid=0, y=0, w=1 within 1 cycle; g_n=0, sel=2 -> y=d[2] next cycle.
- Scan, DWELL=4, out_ready=1 -> captures at out_ch 0,1,...,7,0 spaced 5 cycles; scan_wrap high only in the cycle after out_ch=7 is captured.
- Scan with out_ready=0 for 10 cycles at out_ch=3 -> y/out_ch/out_valid stable; on out_ready=1 the next capture is out_ch=4 and no channel is skipped.
- rst_n pulsed low mid-scan (pointer=5) -> outputs go to reset values immediately; after release with mode=1, the first capture is out_ch=0.
- MUX_SCAN_CHAN_MASK_EN, chan_mask=8'b1000_0101, DWELL=0, out_ready=1 -> out_ch sequence 0,2,7,0; scan_wrap on capture of 7.

Source files
------------

// File: rtl/mux_scan_if.sv
// mux_scan_if: control, data and output handshake bundle for mux_scan.
// Latency: none. This file only groups the wires.
// Backpressure: carries out_valid/out_ready. The master drives the inputs and
//   the ready signal, and the slave (mux_scan) drives the sample outputs.
// Ports: g_n, mode, sel, d, out_ready (master->slave);
//        out_valid, y, w, out_ch, scan_wrap (slave->master);
//        chan_mask (master->slave) only when MUX_SCAN_CHAN_MASK_EN is defined.
interface mux_scan_if #(
  parameter int N_CH = 8,
  parameter int W    = 1
);
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              g_n;
  logic              mode;
  logic [SW-1:0]     sel;
  logic [N_CH*W-1:0] d;
  logic              out_ready;
  logic              out_valid;
  logic [W-1:0]      y;
  logic [W-1:0]      w;
  logic [SW-1:0]     out_ch;
  logic              scan_wrap;
`ifdef MUX_SCAN_CHAN_MASK_EN
  logic [N_CH-1:0]   chan_mask;
`endif

  modport master (
`ifdef MUX_SCAN_CHAN_MASK_EN
    output chan_mask,
`endif
    output g_n, mode, sel, d, out_ready,
    input  out_valid, y, w, out_ch, scan_wrap
  );

  modport slave (
`ifdef MUX_SCAN_CHAN_MASK_EN
    input  chan_mask,
`endif
    input  g_n, mode, sel, d, out_ready,
    output out_valid, y, w, out_ch, scan_wrap
  );
endinterface

// File: rtl/mux_scan.sv
// mux_scan: N_CH x W registered mux with an active-low strobe, manual or auto-scan select.
// Latency: 1 cycle from sel/d to y in manual mode. In scan mode a channel is sampled every DWELL+1 cycles.
// Backpressure: the output slot holds y/w/out_ch stable while out_valid && !out_ready, and the scan waits in EMIT.
// Ports: clk, rst_n (async active-low), bus (mux_scan_if.slave: g_n, mode, sel, d,
//   out_ready in; out_valid, y, w = ~y, out_ch, scan_wrap out).
// Option: MUX_SCAN_CHAN_MASK_EN adds bus.chan_mask. Scan skips disabled channels,
//   and manual capture of a disabled channel returns zero data.
module mux_scan #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input logic       clk,
  input logic       rst_n,
  mux_scan_if.slave bus
);
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [7:0] DLAST = 8'((DWELL > 0) ? DWELL - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_EMIT} state_t;

  state_t          state;
  logic [SW-1:0]   ptr;
  logic [7:0]      cnt;
  logic [W-1:0]    y_q;
  logic [SW-1:0]   out_ch_q;
  logic            out_valid_q;
  logic            scan_wrap_q;
  logic            mode_q;

  logic [N_CH-1:0] en_mask;
  logic [SW-1:0]   first_ch, next_ch, last_ch, cap_ch;
  logic [W-1:0]    cap_dat;
  logic            slot_free, mode_chg, scan_run, man_cap, scan_cap, cap;

`ifdef MUX_SCAN_CHAN_MASK_EN
  assign en_mask = bus.chan_mask;
`else
  assign en_mask = '1;
`endif

  // Data of one channel. Out-of-range or disabled channels read as zero.
  function automatic logic [W-1:0] chan_data(input logic [N_CH*W-1:0] dv,
                                             input logic [N_CH-1:0]   m,
                                             input logic [SW-1:0]     idx);
    logic [W-1:0] r;
    r = '0;
    if (int'(idx) < N_CH) begin
      if (m[idx]) r = dv[int'(idx)*W +: W];
    end
    return r;
  endfunction

  // Cyclic search for an enabled channel. With incl=1 the search starts at p
  // itself, and with incl=0 it starts just after p. With no channel enabled it returns p.
  function automatic logic [SW-1:0] find_en(input logic [SW-1:0]   p,
                                            input logic [N_CH-1:0] m,
                                            input logic            incl);
    logic [SW-1:0] r;
    logic          found;
    int            idx;
    r     = p;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (int'(p) + i + (incl ? 0 : 1)) % N_CH;
      if (!found && m[idx]) begin
        r     = SW'(idx);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Highest enabled index. scan_wrap is raised when this channel is captured.
  function automatic logic [SW-1:0] top_en(input logic [N_CH-1:0] m);
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (m[i]) r = SW'(i);
    end
    return r;
  endfunction

  always_comb begin
    slot_free = !out_valid_q || bus.out_ready;
    mode_chg  = (bus.mode != mode_q);
    // The scan only runs while the strobe is active, the mode is steady and
    // at least one channel is enabled. Otherwise it is held in IDLE.
    scan_run  = bus.mode && !bus.g_n && !mode_chg && (en_mask != '0);
    man_cap   = !bus.mode && !bus.g_n;
    scan_cap  = scan_run && (state == S_EMIT);
    cap       = slot_free && (man_cap || scan_cap);
    first_ch  = find_en('0, en_mask, 1'b1);
    next_ch   = find_en(ptr, en_mask, 1'b0);
    last_ch   = top_en(en_mask);
    cap_ch    = bus.mode ? ptr : bus.sel;
    cap_dat   = chan_data(bus.d, en_mask, cap_ch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      y_q         <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      scan_wrap_q <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      mode_q      <= bus.mode;
      scan_wrap_q <= 1'b0;

      // Output slot
      if (cap) begin
        y_q         <= cap_dat;
        out_ch_q    <= cap_ch;
        out_valid_q <= 1'b1;
        scan_wrap_q <= scan_cap && (cap_ch == last_ch);
      end else if (slot_free) begin
        out_valid_q <= 1'b0;
        // With the strobe inactive, the idle output shows the 74151 disabled level.
        if (bus.g_n) y_q <= '0;
      end

      // Scan sequencer
      if (!scan_run) begin
        state <= S_IDLE;
        ptr   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            ptr   <= first_ch;
            cnt   <= '0;
            state <= (DWELL == 0) ? S_EMIT : S_DWELL;
          end
          S_DWELL: begin
            if (cnt == DLAST) begin
              cnt   <= '0;
              state <= S_EMIT;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_EMIT: begin
            // Wait here until the slot frees. The sample is taken on that edge.
            if (slot_free) begin
              ptr   <= next_ch;
              cnt   <= '0;
              state <= (DWELL == 0) ? S_EMIT : S_DWELL;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.y         = y_q;
  assign bus.w         = ~y_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.scan_wrap = scan_wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: self-checking bench for mux_scan (N_CH=8, W=4, DWELL=4).
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: drives out_ready both held high and randomly stalled.
module tb_mux_scan;
  localparam int N  = 8;
  localparam int WD = 4;
  localparam int DW = 4;
  localparam int SB = 3;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  mux_scan_if #(.N_CH(N), .W(WD)) bus ();

  mux_scan #(.N_CH(N), .W(WD), .DWELL(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference view of one channel: slice of d, zero when out of range or disabled.
  function automatic logic [WD-1:0] chan(input logic [N*WD-1:0] dd, input int k);
    logic [WD-1:0] r;
    r = '0;
    if (k >= 0 && k < N) begin
      r = dd[k*WD +: WD];
`ifdef MUX_SCAN_CHAN_MASK_EN
      if (!bus.chan_mask[k]) r = '0;
`endif
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b1;
    bus.g_n       = 1'b1;
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.d         = '0;
    bus.out_ready = 1'b1;
`ifdef MUX_SCAN_CHAN_MASK_EN
    bus.chan_mask = '1;
`endif
    #3 rst_n = 1'b0;
    #4;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.y !== 4'h0) begin miscompares++; $display("FAIL reset_y: got %h want 0", bus.y); end
    vectors++; if (bus.w !== 4'hF) begin miscompares++; $display("FAIL reset_w: got %h want f", bus.w); end
    vectors++; if (bus.out_ch !== 3'd0) begin miscompares++; $display("FAIL reset_ch: got %0d want 0", bus.out_ch); end
    vectors++; if (bus.scan_wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap: got %b want 0", bus.scan_wrap); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_manual_fixed();
    logic [7:0] pat;
    pat = 8'b1010_0110;
    for (int k = 0; k < N; k++) bus.d[k*WD +: WD] = {WD{pat[k]}};
    bus.mode = 1'b0; bus.g_n = 1'b0; bus.out_ready = 1'b1; bus.sel = 3'd1;
    tick();
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL man1_valid: got %b want 1", bus.out_valid); end
    vectors++; if (bus.y !== 4'hF) begin miscompares++; $display("FAIL man1_y: got %h want f", bus.y); end
    vectors++; if (bus.w !== 4'h0) begin miscompares++; $display("FAIL man1_w: got %h want 0", bus.w); end
    vectors++; if (bus.out_ch !== 3'd1) begin miscompares++; $display("FAIL man1_ch: got %0d want 1", bus.out_ch); end
    bus.sel = 3'd7;
    tick();
    vectors++; if (bus.y !== 4'hF) begin miscompares++; $display("FAIL man7_y: got %h want f", bus.y); end
    vectors++; if (bus.out_ch !== 3'd7) begin miscompares++; $display("FAIL man7_ch: got %0d want 7", bus.out_ch); end
  endtask

  task automatic test_gate();
    bus.g_n = 1'b1;
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL gate_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.y !== 4'h0) begin miscompares++; $display("FAIL gate_y: got %h want 0", bus.y); end
    vectors++; if (bus.w !== 4'hF) begin miscompares++; $display("FAIL gate_w: got %h want f", bus.w); end
    vectors++; if (bus.out_ch !== 3'd7) begin miscompares++; $display("FAIL gate_ch_hold: got %0d want 7", bus.out_ch); end
    bus.g_n = 1'b0; bus.sel = 3'd2;
    tick();
    vectors++; if (bus.y !== chan(bus.d, 2)) begin miscompares++; $display("FAIL gate_resume_y: got %h want %h", bus.y, chan(bus.d, 2)); end
    // A pending sample must survive the strobe going inactive.
    bus.out_ready = 1'b0; bus.sel = 3'd1;
    tick();
    bus.g_n = 1'b1;
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.y !== 4'hF || bus.out_ch !== 3'd2) begin
      miscompares++; $display("FAIL gate_pending: got v=%b y=%h ch=%0d want v=1 y=f ch=2", bus.out_valid, bus.y, bus.out_ch);
    end
    bus.out_ready = 1'b1;
    tick();
    vectors++; if (bus.out_valid !== 1'b0 || bus.y !== 4'h0) begin
      miscompares++; $display("FAIL gate_drain: got v=%b y=%h want v=0 y=0", bus.out_valid, bus.y);
    end
  endtask

  task automatic test_manual_random();
    logic          ev;
    logic [WD-1:0] ey;
    logic [SB-1:0] ech;
    logic          g, rdy;
    logic [SB-1:0] s;
    ev = 1'b0; ey = '0; ech = '0;
    bus.mode = 1'b0;
    for (int i = 0; i < 60; i++) begin
      g   = (i == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      rdy = (i == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      s   = SB'($urandom_range(0, N - 1));
      bus.g_n = g; bus.out_ready = rdy; bus.sel = s; bus.d = $urandom;
      if (!ev || rdy) begin
        if (!g) begin ev = 1'b1; ey = chan(bus.d, int'(s)); ech = s; end
        else begin ev = 1'b0; ey = '0; end
      end
      tick();
      vectors++; if (bus.out_valid !== ev || bus.y !== ey || bus.w !== ~ey || bus.out_ch !== ech) begin
        miscompares++;
        $display("FAIL man_rand[%0d]: got v=%b y=%h w=%h ch=%0d want v=%b y=%h w=%h ch=%0d",
                 i, bus.out_valid, bus.y, bus.w, bus.out_ch, ev, ey, ~ey, ech);
      end
    end
  endtask

  task automatic test_scan();
    bit found;
    int ch;
    logic ev;
    bus.g_n = 1'b1; bus.mode = 1'b0; bus.out_ready = 1'b1; bus.d = $urandom;
    tick();
    bus.mode = 1'b1; bus.g_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (bus.out_valid) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL scan_start: got no capture want capture within 30 cycles"); end
    // From the first capture on, a new channel appears every DW+1 cycles.
    for (int t = 0; t < 45; t++) begin
      if (t > 0) tick();
      ev = ((t % (DW + 1)) == 0);
      ch = (t / (DW + 1)) % N;
      vectors++; if (bus.out_valid !== ev || bus.out_ch !== SB'(ch) || bus.y !== chan(bus.d, ch) ||
                     bus.scan_wrap !== (ev && ch == N - 1)) begin
        miscompares++;
        $display("FAIL scan[%0d]: got v=%b ch=%0d y=%h wrap=%b want v=%b ch=%0d y=%h wrap=%b",
                 t, bus.out_valid, bus.out_ch, bus.y, bus.scan_wrap, ev, ch, chan(bus.d, ch), ev && ch == N - 1);
      end
    end
  endtask

  task automatic test_stall();
    bit found;
    logic [WD-1:0] ey;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (bus.out_valid && bus.out_ch == 3'd3) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL stall_find: got no ch3 capture want one"); end
    bus.out_ready = 1'b0;
    ey = chan(bus.d, 3);
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd3 || bus.y !== ey) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got v=%b ch=%0d y=%h want v=1 ch=3 y=%h", i, bus.out_valid, bus.out_ch, bus.y, ey);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 3'd4 || bus.y !== chan(bus.d, 4)) begin
      miscompares++; $display("FAIL stall_next: got v=%b ch=%0d want v=1 ch=4", bus.out_valid, bus.out_ch);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.out_valid) found = 1'b1;
    end
    vectors++; if (!found || bus.out_ch !== 3'd5) begin
      miscompares++; $display("FAIL stall_after: got found=%b ch=%0d want found=1 ch=5", found, bus.out_ch);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (bus.out_valid && bus.out_ch == 3'd5) found = 1'b1;
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL rstmid_find: got no ch5 capture want one"); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0 || bus.y !== 4'h0 || bus.w !== 4'hF || bus.out_ch !== 3'd0 || bus.scan_wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async: got v=%b y=%h w=%h ch=%0d wrap=%b want 0 0 f 0 0", bus.out_valid, bus.y, bus.w, bus.out_ch, bus.scan_wrap);
    end
    tick();
    tick();
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (bus.out_valid) found = 1'b1;
    end
    vectors++; if (!found || bus.out_ch !== 3'd0 || bus.y !== chan(bus.d, 0)) begin
      miscompares++; $display("FAIL rstmid_first: got found=%b ch=%0d y=%h want found=1 ch=0 y=%h", found, bus.out_ch, bus.y, chan(bus.d, 0));
    end
  endtask

`ifdef MUX_SCAN_CHAN_MASK_EN
  task automatic test_chan_mask();
    int exp_ch[4];
    int k;
    int nv;
    exp_ch[0] = 0; exp_ch[1] = 2; exp_ch[2] = 7; exp_ch[3] = 0;
    bus.g_n = 1'b1; bus.mode = 1'b0; bus.out_ready = 1'b1; bus.d = $urandom;
    bus.chan_mask = 8'b1000_0101;
    tick();
    bus.g_n = 1'b0; bus.mode = 1'b1;
    k = 0;
    for (int i = 0; i < 80 && k < 4; i++) begin
      tick();
      if (bus.out_valid) begin
        vectors++; if (bus.out_ch !== SB'(exp_ch[k]) || bus.y !== chan(bus.d, exp_ch[k]) || bus.scan_wrap !== (exp_ch[k] == 7)) begin
          miscompares++;
          $display("FAIL mask_seq[%0d]: got ch=%0d y=%h wrap=%b want ch=%0d y=%h wrap=%b",
                   k, bus.out_ch, bus.y, bus.scan_wrap, exp_ch[k], chan(bus.d, exp_ch[k]), exp_ch[k] == 7);
        end
        k++;
      end
    end
    vectors++; if (k != 4) begin miscompares++; $display("FAIL mask_count: got %0d captures want 4", k); end
    // No enabled channel: the scan must never start.
    bus.mode = 1'b0; bus.g_n = 1'b1;
    tick();
    bus.chan_mask = '0; bus.mode = 1'b1; bus.g_n = 1'b0;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.out_valid) nv++;
    end
    vectors++; if (nv != 0) begin miscompares++; $display("FAIL mask_zero: got %0d captures want 0", nv); end
    // Manual capture of a disabled channel yields zero data.
    bus.chan_mask = 8'b1000_0101; bus.mode = 1'b0; bus.sel = 3'd1; bus.d = '1;
    tick();
    vectors++; if (bus.out_valid !== 1'b1 || bus.y !== 4'h0 || bus.out_ch !== 3'd1) begin
      miscompares++; $display("FAIL mask_manual: got v=%b y=%h ch=%0d want v=1 y=0 ch=1", bus.out_valid, bus.y, bus.out_ch);
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_manual_fixed();
    test_gate();
    test_manual_random();
    test_scan();
    test_stall();
    test_reset_mid();
`ifdef MUX_SCAN_CHAN_MASK_EN
    test_chan_mask();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
